// File: rtl/if_stage_pipeline.sv
// Instruction-fetch stage: PC register, PC+4, branch redirect, IF/ID register and stall watchdog.
// Define FETCH_PERF_CNT_EN to build the stall_cycles/flush_count performance counters.
module if_stage_pipeline #(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [31:0]          NOP_INSTR = 32'h0000_0000,
  parameter int unsigned          MAX_STALL = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                PCWrite,
  input  logic                IF_ID_Write,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic [PC_WIDTH-1:0] IF_ID_PC_plus4,
  output logic [31:0]         IF_ID_Instruction,
  output logic                IF_ID_Valid,
  output logic [4:0]          IF_ID_RegisterRs,
  output logic [4:0]          IF_ID_RegisterRt,
  output logic                stall_active,
  output logic                stall_timeout,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count
);

  localparam int unsigned CNT_W = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  fetch_state_t        state, state_next;
  logic [PC_WIDTH-1:0] pc, pc_next, pc_plus4;
  logic [CNT_W-1:0]    stall_cnt, stall_cnt_next;
  logic                timeout_next;

  assign pc_plus4  = pc + PC_WIDTH'(4);
  assign imem_addr = pc;

  // A taken branch outranks any stall: the stalled instruction is on the wrong path.
  always_comb begin
    pc_next = pc_plus4;
    if (branch_taken)
      pc_next = {branch_target[PC_WIDTH-1:2], 2'b00};
    else if (!PCWrite)
      pc_next = pc;
  end

  always_ff @(posedge clk) begin
    if (reset)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset || branch_taken) begin
      IF_ID_Instruction <= NOP_INSTR;
      IF_ID_PC_plus4    <= '0;
      IF_ID_Valid       <= 1'b0;
    end else if (IF_ID_Write) begin
      IF_ID_Instruction <= imem_data;
      IF_ID_PC_plus4    <= pc_plus4;
      IF_ID_Valid       <= 1'b1;
    end
  end

  assign IF_ID_RegisterRs = IF_ID_Instruction[25:21];
  assign IF_ID_RegisterRt = IF_ID_Instruction[20:16];

  // State records the action taken at the last edge; the stall counter saturates at MAX_STALL.
  always_comb begin
    state_next     = state;
    stall_cnt_next = stall_cnt;
    timeout_next   = stall_timeout;
    if (branch_taken) begin
      state_next     = FLUSH;
      stall_cnt_next = '0;
    end else if (!IF_ID_Write) begin
      state_next = STALL;
      if (stall_cnt != CNT_MAX)
        stall_cnt_next = stall_cnt + 1'b1;
      if (stall_cnt_next == CNT_MAX)
        timeout_next = 1'b1;
    end else begin
      state_next     = RUN;
      stall_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state         <= state_next;
      stall_cnt     <= stall_cnt_next;
      stall_timeout <= timeout_next;
    end
  end

  assign stall_active = (state == STALL);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (state_next == STALL)
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (branch_taken)
        flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
